// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, REQ, FILL} icache_state_t;

  // Per-way lookup result for the currently addressed set.
  typedef struct packed {
    logic  valid;
    logic  hit;
    word_t word;
  } line_rd_t;

  function automatic int off_width(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int sets, input int line_words);
    return 32 - $clog2(sets) - $clog2(line_words) - 2;
  endfunction

  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_way_array.sv
// One way of the instruction cache: valid/tag/data flops with a combinational
// lookup port, a whole-line write port and a clear-all for flushes.
module icache_way_array
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 16,
  parameter int OFF_W      = off_width(LINE_WORDS),
  parameter int IDX_W      = idx_width(SETS),
  parameter int TAG_W      = tag_width(SETS, LINE_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W-1:0]        rd_idx,
  input  logic [TAG_W-1:0]        rd_tag,
  input  logic [OFF_W-1:0]        rd_off,
  output line_rd_t                rd,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic                    wr_valid,
  input  word_t [LINE_WORDS-1:0]  wr_line,
  input  logic                    clear_all
);

  logic [SETS-1:0]        valid_q;
  logic [TAG_W-1:0]       tag_q  [SETS];
  word_t [LINE_WORDS-1:0] data_q [SETS];

  always_comb begin
    rd.valid = valid_q[rd_idx];
    rd.hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd.word  = data_q[rd_idx][rd_off];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  // Tags and data stay unreset; valid_q guards every lookup.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with round-robin replacement and flush.
// Define ICACHE_PERF_CNT_EN to add saturating hit/miss counters (perf_hit, perf_miss).
module icache_assoc
  import icache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  input  logic        inst_flush,
  output logic [31:0] inst_data,
  output logic        inst_ok,
  output logic [31:0] inst_addr_mmu,
  output logic        inst_read_req,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_read_data,
  input  logic        mmu_valid,
  input  logic        mmu_last
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
`endif
);

  localparam int OFF_W = off_width(LINE_WORDS);
  localparam int IDX_W = idx_width(SETS);
  localparam int TAG_W = tag_width(SETS, LINE_WORDS);
  localparam int WAY_W = way_width(WAYS);

  icache_state_t          state;
  logic [29:0]            miss_word_addr;
  logic [WAY_W-1:0]       victim_q;
  logic [WAY_W-1:0]       victim;
  word_t [LINE_WORDS-1:0] fill_buf;
  word_t [LINE_WORDS-1:0] fill_line;
  logic [OFF_W-1:0]       beat_cnt;
  logic [WAY_W-1:0]       rr_ptr [SETS];
  logic                   flush_pending;
  line_rd_t               rd [WAYS];
  logic                   hit;
  word_t                  hit_word;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [OFF_W-1:0] miss_off;
  logic             unused_addr_lsb;

  assign req_tag         = inst_addr[31:32-TAG_W];
  assign req_idx         = inst_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign req_off         = inst_addr[OFF_W+1:2];
  assign miss_tag        = miss_word_addr[29:30-TAG_W];
  assign miss_idx        = miss_word_addr[IDX_W+OFF_W-1:OFF_W];
  assign miss_off        = miss_word_addr[OFF_W-1:0];
  assign unused_addr_lsb = ^inst_addr[1:0];

  logic miss, fill_done, clear_all;
  assign miss      = (state == IDLE) && inst_en && !hit;
  assign fill_done = (state == FILL) && mmu_valid && mmu_last;
  // A flush seen at any point of a refill empties the whole cache on return to IDLE.
  assign clear_all = ((state == IDLE) && inst_flush) ||
                     (fill_done && (flush_pending || inst_flush));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way_array #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS),
      .OFF_W(OFF_W), .IDX_W(IDX_W), .TAG_W(TAG_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (req_idx),
      .rd_tag   (req_tag),
      .rd_off   (req_off),
      .rd       (rd[w]),
      .wr_en    (fill_done && (victim_q == WAY_W'(w))),
      .wr_idx   (miss_idx),
      .wr_tag   (miss_tag),
      .wr_valid (!(flush_pending || inst_flush)),
      .wr_line  (fill_line),
      .clear_all(clear_all)
    );
  end

  // Scanning downwards lets the lowest matching / lowest invalid way win.
  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    victim   = rr_ptr[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd[w].hit) begin
        hit      = 1'b1;
        hit_word = rd[w].word;
      end
      if (!rd[w].valid) victim = WAY_W'(w);
    end
  end

  always_comb begin
    fill_line           = fill_buf;
    fill_line[beat_cnt] = inst_read_data;
  end

  // Outputs are combinational and forced low while reset is asserted.
  always_comb begin
    inst_ok       = 1'b0;
    inst_data     = '0;
    inst_read_req = 1'b0;
    inst_addr_mmu = '0;
    if (rst) begin
      case (state)
        IDLE: if (inst_en) begin
          if (hit) begin
            inst_ok   = 1'b1;
            inst_data = hit_word;
          end else begin
            inst_read_req = 1'b1;
            inst_addr_mmu = {inst_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
          end
        end
        REQ: begin
          inst_read_req = 1'b1;
          inst_addr_mmu = {miss_word_addr[29:OFF_W], {(OFF_W+2){1'b0}}};
        end
        FILL: if (fill_done) begin
          inst_ok   = 1'b1;
          inst_data = fill_line[miss_off];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      miss_word_addr <= '0;
      victim_q       <= '0;
      beat_cnt       <= '0;
      flush_pending  <= 1'b0;
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          miss_word_addr <= inst_addr[31:2];
          victim_q       <= victim;
          state          <= inst_addr_ok ? FILL : REQ;
        end
        REQ: begin
          if (inst_flush) flush_pending <= 1'b1;
          if (inst_addr_ok) state <= FILL;
        end
        FILL: begin
          if (fill_done) begin
            beat_cnt         <= '0;
            flush_pending    <= 1'b0;
            rr_ptr[miss_idx] <= (rr_ptr[miss_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[miss_idx] + 1'b1;
            state            <= IDLE;
          end else begin
            if (inst_flush) flush_pending <= 1'b1;
            if (mmu_valid) beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == FILL) && mmu_valid) fill_buf[beat_cnt] <= inst_read_data;
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if ((state == IDLE) && inst_en && hit && (perf_hit != '1)) perf_hit <= perf_hit + 1'b1;
      if (miss && (perf_miss != '1)) perf_miss <= perf_miss + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: scoreboard of expected fetch responses.
module tb_icache_assoc;

  localparam int LW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_en = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_flush = 1'b0;
  logic [31:0] inst_data;
  logic        inst_ok;
  logic [31:0] inst_addr_mmu;
  logic        inst_read_req;
  logic        inst_addr_ok = 1'b0;
  logic [31:0] inst_read_data = '0;
  logic        mmu_valid = 1'b0;
  logic        mmu_last = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] data;
    bit          hit;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    int          flush_beat;
    bit          hit;
    logic [31:0] data;
  } step_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  icache_assoc #(.WAYS(2), .SETS(64), .LINE_WORDS(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_en       (inst_en),
    .inst_addr     (inst_addr),
    .inst_flush    (inst_flush),
    .inst_data     (inst_data),
    .inst_ok       (inst_ok),
    .inst_addr_mmu (inst_addr_mmu),
    .inst_read_req (inst_read_req),
    .inst_addr_ok  (inst_addr_ok),
    .inst_read_data(inst_read_data),
    .mmu_valid     (mmu_valid),
    .mmu_last      (mmu_last)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .perf_hit      (perf_hit),
    .perf_miss     (perf_miss)
`endif
  );

  // One fetch; on a miss acts as the MMU, returning base+i on beat i.
  // flush_beat: beat index to pulse inst_flush, -2 pulses it in the request cycle.
  task automatic apply_fetch(input logic [31:0] addr, input int ok_delay, input int flush_beat,
                             input logic [31:0] base, output bit hit, output bit ok,
                             output logic [31:0] data, output int req_hi, output bit stable,
                             output bit early_ok, output logic [31:0] mmu_seen);
    hit = 0; ok = 0; data = '0; req_hi = 0; stable = 1; early_ok = 0; mmu_seen = '0;
    @(posedge clk); #1;
    inst_en = 1; inst_addr = addr; inst_addr_ok = (ok_delay == 0); inst_flush = (flush_beat == -2);
    #3;
    if (inst_ok) begin
      hit = 1; ok = 1; data = inst_data;
    end else begin
      mmu_seen = inst_addr_mmu;
      if (inst_read_req) req_hi++;
      for (int c = 1; c <= ok_delay; c++) begin
        @(posedge clk); #1;
        inst_flush = 0;
        inst_addr_ok = (c == ok_delay);
        mmu_valid = 1; mmu_last = 0; inst_read_data = 32'hDEAD_0000 + 32'(c);
        #3;
        if (inst_read_req) req_hi++;
        if (inst_addr_mmu !== mmu_seen) stable = 0;
        if (inst_ok) early_ok = 1;
      end
      for (int b = 0; b < LW; b++) begin
        @(posedge clk); #1;
        inst_addr_ok = 0; mmu_valid = 1; mmu_last = (b == LW - 1);
        inst_read_data = base + 32'(b); inst_flush = (b == flush_beat);
        #3;
        if (inst_read_req) req_hi++;
        if (b == LW - 1) begin
          ok = inst_ok; data = inst_data;
        end else if (inst_ok) begin
          early_ok = 1;
        end
      end
    end
    @(posedge clk); #1;
    inst_en = 0; inst_addr_ok = 0; mmu_valid = 0; mmu_last = 0; inst_flush = 0;
  endtask

  task automatic test_reset();
    inst_en = 1; inst_addr = 32'h0000_1044;
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #3;
    checks++; if (inst_ok !== 1'b0) begin fails++; $display("[TB] FAIL reset_ok: got %b want 0", inst_ok); end
    checks++; if (inst_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_data: got %h want 0", inst_data); end
    checks++; if (inst_read_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b want 0", inst_read_req); end
    checks++; if (inst_addr_mmu !== 32'h0) begin fails++; $display("[TB] FAIL reset_mmu_addr: got %h want 0", inst_addr_mmu); end
    @(posedge clk); #1;
    rst = 1; inst_en = 0;
  endtask

  task automatic test_cold_miss();
    bit h, ok, st, eo; int rq; logic [31:0] d, m; exp_t e;
    exp_q.push_back('{32'h0000_00A1, 1'b0});
    apply_fetch(32'h0000_1044, 0, -1, 32'hA0, h, ok, d, rq, st, eo, m);
    e = exp_q.pop_front();
    checks++; if (m !== 32'h0000_1040) begin fails++; $display("[TB] FAIL cold_mmu_addr: got %h want 00001040", m); end
    checks++; if (rq != 1) begin fails++; $display("[TB] FAIL cold_req_cycles: got %0d want 1", rq); end
    checks++; if (eo !== 1'b0) begin fails++; $display("[TB] FAIL cold_early_ok: got %b want 0", eo); end
    checks++; if (h !== e.hit) begin fails++; $display("[TB] FAIL cold_hit: got %b want %b", h, e.hit); end
    checks++; if (ok !== 1'b1 || d !== e.data) begin fails++; $display("[TB] FAIL cold_data: got ok=%b %h want ok=1 %h", ok, d, e.data); end
    exp_q.push_back('{32'h0000_00AF, 1'b1});
    apply_fetch(32'h0000_107C, 0, -1, 32'h0, h, ok, d, rq, st, eo, m);
    e = exp_q.pop_front();
    checks++; if (h !== e.hit) begin fails++; $display("[TB] FAIL refetch_hit: got %b want %b", h, e.hit); end
    checks++; if (d !== e.data) begin fails++; $display("[TB] FAIL refetch_data: got %h want %h", d, e.data); end
  endtask

  task automatic test_associativity();
    bit h, ok, st, eo; int rq; logic [31:0] d, m; exp_t e;
    step_t steps [8] = '{
      '{32'h0000_1000, 32'h100, -1, 1'b0, 32'h100},
      '{32'h0001_1000, 32'h200, -1, 1'b0, 32'h200},
      '{32'h0002_1000, 32'h300, -1, 1'b0, 32'h300},
      '{32'h0001_1000, 32'h0,   -1, 1'b1, 32'h200},
      '{32'h0002_1000, 32'h0,   -1, 1'b1, 32'h300},
      '{32'h0000_1000, 32'h400, -1, 1'b0, 32'h400},
      '{32'h0002_1000, 32'h0,   -1, 1'b1, 32'h300},
      '{32'h0000_1044, 32'h0,   -1, 1'b1, 32'h0A1}
    };
    foreach (steps[i]) begin
      exp_q.push_back('{steps[i].data, steps[i].hit});
      apply_fetch(steps[i].addr, 0, steps[i].flush_beat, steps[i].base, h, ok, d, rq, st, eo, m);
      e = exp_q.pop_front();
      checks++; if (h !== e.hit) begin fails++; $display("[TB] FAIL assoc_hit[%0d] %h: got %b want %b", i, steps[i].addr, h, e.hit); end
      checks++; if (ok !== 1'b1 || d !== e.data) begin fails++; $display("[TB] FAIL assoc_data[%0d] %h: got ok=%b %h want %h", i, steps[i].addr, ok, d, e.data); end
    end
  endtask

  task automatic test_delayed_handshake();
    bit h, ok, st, eo; int rq; logic [31:0] d, m; exp_t e;
    exp_q.push_back('{32'h0000_0502, 1'b0});
    apply_fetch(32'h0000_2008, 5, -1, 32'h500, h, ok, d, rq, st, eo, m);
    e = exp_q.pop_front();
    checks++; if (rq != 6) begin fails++; $display("[TB] FAIL delay_req_cycles: got %0d want 6", rq); end
    checks++; if (st !== 1'b1) begin fails++; $display("[TB] FAIL delay_addr_stable: got %b want 1", st); end
    checks++; if (m !== 32'h0000_2000) begin fails++; $display("[TB] FAIL delay_mmu_addr: got %h want 00002000", m); end
    checks++; if (eo !== 1'b0) begin fails++; $display("[TB] FAIL delay_early_ok: got %b want 0", eo); end
    checks++; if (h !== e.hit) begin fails++; $display("[TB] FAIL delay_hit: got %b want %b", h, e.hit); end
    checks++; if (ok !== 1'b1 || d !== e.data) begin fails++; $display("[TB] FAIL delay_data: got ok=%b %h want %h", ok, d, e.data); end
  endtask

  task automatic test_flush();
    bit h, ok, st, eo; int rq; logic [31:0] d, m; exp_t e;
    step_t steps [8] = '{
      '{32'h0000_3010, 32'h600, 7,  1'b0, 32'h604},
      '{32'h0000_1000, 32'h0C0, -1, 1'b0, 32'h0C0},
      '{32'h0000_1044, 32'h0A0, -1, 1'b0, 32'h0A1},
      '{32'h0000_3010, 32'h700, -1, 1'b0, 32'h704},
      '{32'h0000_3010, 32'h0,   -1, 1'b1, 32'h704},
      '{32'h0000_1044, 32'h0,   -2, 1'b1, 32'h0A1},
      '{32'h0000_1044, 32'h0B0, -1, 1'b0, 32'h0B1},
      '{32'h0000_3010, 32'h710, -1, 1'b0, 32'h714}
    };
    foreach (steps[i]) begin
      exp_q.push_back('{steps[i].data, steps[i].hit});
      apply_fetch(steps[i].addr, 0, steps[i].flush_beat, steps[i].base, h, ok, d, rq, st, eo, m);
      e = exp_q.pop_front();
      checks++; if (h !== e.hit) begin fails++; $display("[TB] FAIL flush_hit[%0d] %h: got %b want %b", i, steps[i].addr, h, e.hit); end
      checks++; if (ok !== 1'b1 || d !== e.data) begin fails++; $display("[TB] FAIL flush_data[%0d] %h: got ok=%b %h want %h", i, steps[i].addr, ok, d, e.data); end
    end
  endtask

  task automatic test_async_reset();
    bit h, ok, st, eo; int rq; logic [31:0] d, m; exp_t e;
    @(posedge clk); #1;
    inst_en = 1; inst_addr = 32'h0000_4000; inst_addr_ok = 1;
    @(posedge clk); #1;
    inst_addr_ok = 0;
    for (int b = 0; b < LW; b++) begin
      mmu_valid = 1; mmu_last = (b == LW - 1); inst_read_data = 32'h900 + 32'(b);
      if (b < LW - 1) begin @(posedge clk); #1; end
    end
    #2;
    checks++; if (inst_ok !== 1'b1 || inst_data !== 32'h900) begin fails++; $display("[TB] FAIL arst_last_beat: got ok=%b %h want ok=1 00000900", inst_ok, inst_data); end
    rst = 0;
    #1;
    checks++; if (inst_ok !== 1'b0) begin fails++; $display("[TB] FAIL arst_ok: got %b want 0", inst_ok); end
    checks++; if (inst_data !== 32'h0) begin fails++; $display("[TB] FAIL arst_data: got %h want 0", inst_data); end
    checks++; if (inst_read_req !== 1'b0) begin fails++; $display("[TB] FAIL arst_req: got %b want 0", inst_read_req); end
    checks++; if (inst_addr_mmu !== 32'h0) begin fails++; $display("[TB] FAIL arst_mmu_addr: got %h want 0", inst_addr_mmu); end
    mmu_valid = 0; mmu_last = 0; inst_en = 0;
    @(posedge clk); #1;
    rst = 1; inst_en = 1; inst_addr = 32'h0000_3010;
    #2;
    checks++; if (inst_read_req !== 1'b1 || inst_ok !== 1'b0) begin fails++; $display("[TB] FAIL arst_first_fetch: got req=%b ok=%b want req=1 ok=0", inst_read_req, inst_ok); end
    inst_en = 0;
    exp_q.push_back('{32'h0000_0804, 1'b0});
    apply_fetch(32'h0000_3010, 0, -1, 32'h800, h, ok, d, rq, st, eo, m);
    e = exp_q.pop_front();
    checks++; if (h !== e.hit) begin fails++; $display("[TB] FAIL arst_refill_hit: got %b want %b", h, e.hit); end
    checks++; if (ok !== 1'b1 || d !== e.data) begin fails++; $display("[TB] FAIL arst_refill_data: got ok=%b %h want %h", ok, d, e.data); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < LW; i++) begin
      int o;
      o = (i * 5) % LW;
      @(posedge clk); #1;
      inst_en = 1; inst_addr = 32'h0000_3000 + 32'(o * 4);
      exp_q.push_back('{32'h800 + 32'(o), 1'b1});
      #3;
      if (inst_ok) begin
        e = exp_q.pop_front();
        checks++; if (inst_data !== e.data) begin fails++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", i, inst_data, e.data); end
      end
    end
    @(posedge clk); #1;
    inst_en = 0;
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("[TB] FAIL b2b_missing_responses: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    bit h, ok, st, eo; int rq; logic [31:0] d, m;
    logic [31:0] lines [3] = '{32'h0000_5000, 32'h0000_5040, 32'h0000_5080};
    @(posedge clk); #1;
    rst = 0;
    #2;
    checks++; if (perf_hit !== 32'h0 || perf_miss !== 32'h0) begin fails++; $display("[TB] FAIL perf_reset: got hit=%0d miss=%0d want 0 0", perf_hit, perf_miss); end
    @(posedge clk); #1;
    rst = 1;
    foreach (lines[i]) apply_fetch(lines[i], 0, -1, 32'h1000, h, ok, d, rq, st, eo, m);
    for (int i = 0; i < 10; i++) apply_fetch(lines[i % 3] + 32'(4 * i), 0, -1, 32'h0, h, ok, d, rq, st, eo, m);
    #1;
    checks++; if (perf_miss !== 32'd3) begin fails++; $display("[TB] FAIL perf_miss: got %0d want 3", perf_miss); end
    checks++; if (perf_hit !== 32'd10) begin fails++; $display("[TB] FAIL perf_hit: got %0d want 10", perf_hit); end
  endtask
`endif

  initial begin
    $display("[TB] icache_assoc bench start");
    test_reset();
    test_cold_miss();
    test_associativity();
    test_delayed_handshake();
    test_flush();
    test_async_reset();
    test_back_to_back();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
